// File: rtl/qam_symbol_packer.sv
`default_nettype none
// ============================================================================
// qam_symbol_packer : slices a framed word stream MSB-first into iqam-bit
// symbols and splits each into 5-bit re/im mapper indices.
// Optional macro QAM_SYMBOL_PACKER_SYMCNT_EN adds the osym_cnt output.
// Rev 1.0
// ============================================================================
module qam_symbol_packer #(
  parameter int pIN_W = 8
) (
  input  logic             iclk,
  input  logic             ireset,
  input  logic             iclkena,
  input  logic             ival,
  input  logic             isop,
  input  logic             ieop,
  input  logic [3:0]       iqam,
  input  logic [pIN_W-1:0] idat,
  output logic             ordy,
  input  logic             irdy,
  output logic             oval,
  output logic             osop,
  output logic             oeop,
  output logic [3:0]       oqam,
`ifdef QAM_SYMBOL_PACKER_SYMCNT_EN
  output logic [15:0]      osym_cnt,
`endif
  output logic [4:0]       odat_re,
  output logic [4:0]       odat_im
);

  localparam int BW = pIN_W + 9;
  localparam int CW = $clog2(BW + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [BW-1:0]   bitbuf, bitbuf_nxt;
  logic [CW-1:0]   cnt, cnt_nxt, rem;
  logic [3:0]      qb, qb_nxt, qsan;
  logic            sop_arm, sop_arm_nxt;
  logic            accept, start, avail, pop, last;
  logic [9:0]      sym;
  logic [3:0]      half;
  logic [4:0]      re5, im5;

  // Valid bits live left-aligned in bitbuf; everything below cnt is kept zero,
  // which makes the padded flush symbol fall out of the normal extraction.
  assign ordy   = iclkena & ireset & (state != FLUSH) & (cnt <= CW'(9));
  assign accept = ival & ordy;
  assign start  = accept & isop;
  assign avail  = ((state == RUN) && (cnt >= CW'(qb))) || ((state == FLUSH) && (cnt != '0));
  assign pop    = iclkena & (~oval | irdy) & avail & ~start;
  assign rem    = (cnt > CW'(qb)) ? cnt - CW'(qb) : '0;
  assign last   = pop && (state == FLUSH) && (rem == '0);
  assign qsan   = ((iqam == 4'd0) || (iqam > 4'd10)) ? 4'd2 : iqam;

  assign sym  = bitbuf[BW-1 -: 10] >> (4'd10 - qb);
  assign half = qb >> 1;
  assign re5  = 5'(sym >> half);
  assign im5  = (qb == 4'd1) ? 5'(sym) : 5'(sym & ((10'd1 << half) - 10'd1));

  always_comb begin
    state_nxt   = state;
    bitbuf_nxt  = bitbuf;
    cnt_nxt     = cnt;
    qb_nxt      = qb;
    sop_arm_nxt = sop_arm;
    if (pop) begin
      bitbuf_nxt  = bitbuf << qb;
      cnt_nxt     = rem;
      sop_arm_nxt = 1'b0;
      if (last) state_nxt = IDLE;
    end
    if (start) begin
      // A start word in RUN abandons whatever is left of the old frame.
      bitbuf_nxt  = {idat, 9'b0};
      cnt_nxt     = CW'(pIN_W);
      qb_nxt      = qsan;
      sop_arm_nxt = 1'b1;
      state_nxt   = ieop ? FLUSH : RUN;
    end else if (accept && (state == RUN)) begin
      bitbuf_nxt = bitbuf_nxt | ({idat, 9'b0} >> cnt_nxt);
      cnt_nxt    = cnt_nxt + CW'(pIN_W);
      if (ieop) state_nxt = FLUSH;
    end
  end

  always_ff @(posedge iclk) begin
    if (!ireset) state <= IDLE;
    else if (iclkena) state <= state_nxt;
  end

  always_ff @(posedge iclk) begin
    if (!ireset) begin
      bitbuf  <= '0;
      cnt     <= '0;
      qb      <= 4'd2;
      sop_arm <= 1'b0;
      oval    <= 1'b0;
      osop    <= 1'b0;
      oeop    <= 1'b0;
      oqam    <= 4'd2;
      odat_re <= '0;
      odat_im <= '0;
    end else if (iclkena) begin
      bitbuf  <= bitbuf_nxt;
      cnt     <= cnt_nxt;
      qb      <= qb_nxt;
      sop_arm <= sop_arm_nxt;
      if (pop) begin
        oval    <= 1'b1;
        osop    <= sop_arm;
        oeop    <= last;
        oqam    <= qb;
        odat_re <= re5;
        odat_im <= im5;
      end else if (irdy) begin
        oval <= 1'b0;
      end
    end
  end

`ifdef QAM_SYMBOL_PACKER_SYMCNT_EN
  always_ff @(posedge iclk) begin
    if (!ireset) begin
      osym_cnt <= '0;
    end else if (iclkena && pop) begin
      if (sop_arm)                  osym_cnt <= '0;
      else if (osym_cnt != 16'hFFFF) osym_cnt <= osym_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_qam_symbol_packer.sv
`default_nettype none
// ============================================================================
// tb_qam_symbol_packer : randomized + directed scoreboard bench for the packer.
// Rev 1.0
// ============================================================================
module tb_qam_symbol_packer;

  localparam int W = 8;

  logic         iclk = 1'b0;
  logic         ireset = 1'b0;
  logic         iclkena = 1'b1;
  logic         ival = 1'b0;
  logic         isop = 1'b0;
  logic         ieop = 1'b0;
  logic [3:0]   iqam = 4'd2;
  logic [W-1:0] idat = '0;
  logic         irdy = 1'b1;
  logic         ordy, oval, osop, oeop;
  logic [3:0]   oqam;
  logic [4:0]   odat_re, odat_im;
`ifdef QAM_SYMBOL_PACKER_SYMCNT_EN
  logic [15:0]  osym_cnt;
`endif

  qam_symbol_packer #(.pIN_W(W)) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival),
    .isop(isop), .ieop(ieop), .iqam(iqam), .idat(idat), .ordy(ordy),
    .irdy(irdy), .oval(oval), .osop(osop), .oeop(oeop), .oqam(oqam),
`ifdef QAM_SYMBOL_PACKER_SYMCNT_EN
    .osym_cnt(osym_cnt),
`endif
    .odat_re(odat_re), .odat_im(odat_im)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    int re;
    int im;
    int sop;
    int eop;
    int qam;
    int idx;
  } sym_t;

  sym_t expq[$];
  int   n_checks = 0;
  int   n_pass = 0;
  bit   stall = 1'b0;
  bit   rnd = 1'b0;
  bit   prev_hold = 1'b0;
  logic [17:0] prev_word = '0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: concatenate frame bits, cut qb at a time, zero-pad the tail.
  task automatic model_frame(input int q, input logic [7:0] bytes[$], input bit closed);
    int qb, total, pos, idx, v, p, b, h;
    sym_t s;
    qb    = (q == 0 || q > 10) ? 2 : q;
    total = 8 * bytes.size();
    pos   = 0;
    idx   = 0;
    while (pos < total && (closed || pos + qb <= total)) begin
      v = 0;
      for (int k = 0; k < qb; k++) begin
        p = pos + k;
        b = (p < total) ? int'(bytes[p / 8][7 - (p % 8)]) : 0;
        v = v * 2 + b;
      end
      h     = qb / 2;
      s.re  = v / (1 << h);
      s.im  = (qb == 1) ? v : v % (1 << h);
      s.sop = (pos == 0) ? 1 : 0;
      s.eop = (closed && pos + qb >= total) ? 1 : 0;
      s.qam = qb;
      s.idx = idx;
      expq.push_back(s);
      pos += qb;
      if (idx < 65535) idx++;
    end
  endtask

  task automatic send_word(input bit s, input bit e, input logic [3:0] q, input logic [7:0] d);
    int guard;
    guard = 0;
    @(negedge iclk);
    ival = 1'b1; isop = s; ieop = e; iqam = q; idat = d;
    while (!ordy) begin
      @(negedge iclk);
      guard++;
      if (guard > 3000) begin
        check("send_timeout", guard, 0);
        break;
      end
    end
    @(posedge iclk);
    #1;
    ival = 1'b0;
  endtask

  task automatic send_frame(input int q, input logic [7:0] bytes[$]);
    model_frame(q, bytes, 1'b1);
    for (int i = 0; i < bytes.size(); i++)
      send_word(i == 0, i == bytes.size() - 1, (i == 0) ? 4'(q) : 4'($urandom), bytes[i]);
  endtask

  always @(posedge iclk) begin
    #2;
    irdy    = stall ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
    iclkena = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
  end

  // Monitor: pops one expectation per output transfer, and checks that a
  // stalled output stays put.
  always @(negedge iclk) begin
    sym_t e;
    if (ireset) begin
      if (prev_hold) begin
        check("hold_oval", oval, 1);
        check("hold_data", {osop, oeop, oqam, odat_re, odat_im, 1'b0}, prev_word);
      end
      if (oval && irdy && iclkena) begin
        if (expq.size() == 0) begin
          check("unexpected_symbol", expq.size(), 1);
        end else begin
          e = expq.pop_front();
          check("re", odat_re, e.re);
          check("im", odat_im, e.im);
          check("osop", osop, e.sop);
          check("oeop", oeop, e.eop);
          check("oqam", oqam, e.qam);
`ifdef QAM_SYMBOL_PACKER_SYMCNT_EN
          check("osym_cnt", osym_cnt, e.idx);
`endif
        end
      end
    end
    prev_hold = ireset && oval && !(irdy && iclkena);
    prev_word = {osop, oeop, oqam, odat_re, odat_im, 1'b0};
  end

  initial begin
    logic [7:0] b[$];
    int q, n, low, guard;

    repeat (3) @(negedge iclk);
    check("rst_oval", oval, 0);
    check("rst_osop", osop, 0);
    check("rst_oeop", oeop, 0);
    check("rst_re", odat_re, 0);
    check("rst_im", odat_im, 0);
    check("rst_oqam", oqam, 2);
    check("rst_ordy", ordy, 0);
    ireset = 1'b1;

    b = '{8'hB4};              send_frame(2, b);
    b = '{8'hFF, 8'h00};       send_frame(10, b);
    b = '{8'hE0};              send_frame(3, b);
    b = '{8'h80};              send_frame(1, b);
    b = '{8'hB4};              send_frame(0, b);
    b = '{8'h6D};              send_frame(13, b);

    // Backpressure mid-frame: the buffer fills and ordy must drop.
    low = 0;
    b = '{8'hC3, 8'h5A, 8'h0F, 8'hF0};
    fork
      send_frame(2, b);
      begin
        repeat (2) @(posedge iclk);
        stall = 1'b1;
        repeat (5) begin
          @(negedge iclk);
          if (!ordy) low++;
        end
        stall = 1'b0;
      end
    join
    check("ordy_fell", low > 0, 1);

    // Abort: unterminated QPSK frame drained, then a QAM16 start word.
    b = '{8'h5A};
    model_frame(2, b, 1'b0);
    send_word(1'b1, 1'b0, 4'd2, 8'h5A);
    repeat (12) @(posedge iclk);
    b = '{8'h3C, 8'h81};       send_frame(4, b);
    repeat (10) @(posedge iclk);

    // Reset mid-frame with the output stalled.
    stall = 1'b1;
    send_word(1'b1, 1'b0, 4'd4, 8'hA5);
    repeat (3) @(negedge iclk);
    check("pre_rst_oval", oval, 1);
    ireset = 1'b0;
    expq.delete();
    @(negedge iclk);
    check("mid_rst_oval", oval, 0);
    check("mid_rst_oqam", oqam, 2);
    check("mid_rst_osop", osop, 0);
    check("mid_rst_ordy", ordy, 0);
    ireset = 1'b1;
    stall = 1'b0;
    send_word(1'b0, 1'b0, 4'd2, 8'hFF);
    send_word(1'b0, 1'b1, 4'd2, 8'h0F);
    repeat (10) @(posedge iclk);

    // Randomized frames with random gaps, enable and downstream ready.
    rnd = 1'b1;
    for (int f = 0; f < 30; f++) begin
      q = $urandom_range(0, 15);
      n = $urandom_range(1, 5);
      b.delete();
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      if ($urandom_range(0, 3) == 0)
        send_word(1'b0, 1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom));
      send_frame(q, b);
      repeat ($urandom_range(0, 3)) @(posedge iclk);
    end
    rnd = 1'b0;

    guard = 0;
    while (expq.size() != 0 && guard < 3000) begin
      @(posedge iclk);
      guard++;
    end
    repeat (5) @(posedge iclk);
    check("drain_empty", expq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
